// File: rtl/stream_insert_pipe_pkg.sv
// Shared types and keep-lane helpers for the stream header inserter.
// Helpers take keep vectors zero-extended to MAX_BYTES plus the live lane count.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_TAIL = 2'd2
    } state_e;

    localparam int MAX_BYTES = 64;

    function automatic int keep_popcnt(input logic [MAX_BYTES-1:0] keep, input int nb);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < nb && keep[i]) cnt++;
        end
        return cnt;
    endfunction

    // Legal last-beat keep: non-zero and a single run of ones starting at the top lane.
    function automatic logic keep_contig(input logic [MAX_BYTES-1:0] keep, input int nb);
        logic seen_zero;
        logic seen_one;
        logic ok;
        seen_zero = 1'b0;
        seen_one  = 1'b0;
        ok        = 1'b1;
        for (int i = MAX_BYTES-1; i >= 0; i--) begin
            if (i < nb) begin
                if (keep[i]) begin
                    if (seen_zero) ok = 1'b0;
                    seen_one = 1'b1;
                end else begin
                    seen_zero = 1'b1;
                end
            end
        end
        return ok && seen_one;
    endfunction

    function automatic logic [MAX_BYTES-1:0] ones_low(input int n);
        logic [MAX_BYTES-1:0] r;
        for (int i = 0; i < MAX_BYTES; i++) begin
            r[i] = (i < n);
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_insert_pipe_out_slice.sv
// Registered output stage: holds valid/data/keep/last under backpressure.
// o_adv tells the producer when a new beat may be loaded.
module stream_out_slice #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD/8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_load,
    input  logic [DATA_WD-1:0]      i_data,
    input  logic [DATA_BYTE_WD-1:0] i_keep,
    input  logic                    i_last,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [DATA_WD-1:0]      o_data,
    output logic [DATA_BYTE_WD-1:0] o_keep,
    output logic                    o_last,
    output logic                    o_adv
);

    logic                    r_valid;
    logic [DATA_WD-1:0]      r_data;
    logic [DATA_BYTE_WD-1:0] r_keep;
    logic                    r_last;

    assign o_adv = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (o_adv) begin
            r_valid <= i_load;
            if (i_load) begin
                r_data <= i_data;
                r_keep <= i_keep;
                r_last <= i_last;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

// File: rtl/stream_insert_pipe.sv
// Prepends a 0..DATA_BYTE_WD byte header to each packet and re-aligns the payload
// through a carry word; an overflowing last beat spills into one extra tail beat.
//
// state   | meaning
// IDLE    | waiting for the packet header; payload held off
// BODY    | streaming payload, output = {carry, data_in} shifted by the header length
// TAIL    | emitting the spilled remainder of the last payload beat
module stream_insert_pipe #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD/8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD)+1,
    parameter int CNT_WD       = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [LEN_WD-1:0]       hdr_len,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic [CNT_WD-1:0]       pkt_cnt,
    output logic                    err_keep
);
    import stream_pkg::*;

    localparam logic [LEN_WD-1:0] LEN_MAX = LEN_WD'(DATA_BYTE_WD);

    state_e                  r_state;
    logic [LEN_WD-1:0]       r_hdr_n;
    logic [DATA_WD-1:0]      r_carry;
    logic [DATA_BYTE_WD-1:0] r_keep_save;
    logic                    r_err_keep;
    logic [CNT_WD-1:0]       r_pkt_cnt;

    logic                    w_adv;
    logic                    w_fire_in;
    logic                    w_fire_ins;
    logic [LEN_WD-1:0]       w_hdr_n;
    logic [LEN_WD+2:0]       w_shift_bits;
    logic [DATA_BYTE_WD-1:0] w_ones;
    logic [MAX_BYTES-1:0]    w_keep_ext;
    logic [DATA_WD-1:0]      w_body_data;
    logic [DATA_WD-1:0]      w_tail_data;
    logic [DATA_BYTE_WD-1:0] w_body_keep;
    logic [DATA_BYTE_WD-1:0] w_tail_keep;
    logic                    w_ovf;
    logic                    w_keep_bad;
    logic                    w_load;
    logic [DATA_WD-1:0]      w_data_nxt;
    logic [DATA_BYTE_WD-1:0] w_keep_nxt;
    logic                    w_last_nxt;

    assign w_hdr_n      = (hdr_len > LEN_MAX) ? LEN_MAX : hdr_len;
    assign ready_insert = (r_state == ST_IDLE);
    assign ready_in     = (r_state == ST_BODY) && w_adv;
    assign w_fire_in    = valid_in && ready_in;
    assign w_fire_ins   = valid_insert && ready_insert;

    assign w_shift_bits = {r_hdr_n, 3'b000};
    assign w_ones       = DATA_BYTE_WD'(ones_low(int'(r_hdr_n)));
    assign w_keep_ext   = MAX_BYTES'(keep_in);
    assign w_body_data  = DATA_WD'({r_carry, data_in} >> w_shift_bits);
    assign w_tail_data  = DATA_WD'({r_carry, {DATA_WD{1'b0}}} >> w_shift_bits);
    assign w_body_keep  = DATA_BYTE_WD'({w_ones, keep_in} >> r_hdr_n);
    assign w_tail_keep  = DATA_BYTE_WD'({r_keep_save, {DATA_BYTE_WD{1'b0}}} >> r_hdr_n);

    // Header bytes plus valid payload bytes exceed one word: the last beat spills.
    assign w_ovf = (int'(r_hdr_n) + keep_popcnt(w_keep_ext, DATA_BYTE_WD)) > DATA_BYTE_WD;
    assign w_keep_bad = last_in ? !keep_contig(w_keep_ext, DATA_BYTE_WD)
                                : (keep_in != {DATA_BYTE_WD{1'b1}});

    always_comb begin
        w_load     = 1'b0;
        w_data_nxt = w_body_data;
        w_keep_nxt = w_body_keep;
        w_last_nxt = 1'b0;
        case (r_state)
            ST_BODY: begin
                w_load     = w_fire_in;
                w_last_nxt = last_in && !w_ovf;
            end
            ST_TAIL: begin
                w_load     = 1'b1;
                w_data_nxt = w_tail_data;
                w_keep_nxt = w_tail_keep;
                w_last_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_hdr_n     <= '0;
            r_carry     <= '0;
            r_keep_save <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fire_ins) begin
                        r_hdr_n <= w_hdr_n;
                        r_carry <= data_insert;
                        r_state <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (w_fire_in) begin
                        r_carry     <= data_in;
                        r_keep_save <= keep_in;
                        if (last_in) r_state <= w_ovf ? ST_TAIL : ST_IDLE;
                    end
                end
                ST_TAIL: begin
                    if (w_adv) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_keep <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_fire_in && w_keep_bad) r_err_keep <= 1'b1;
            if (valid_out && ready_out && last_out) r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign err_keep = r_err_keep;

    stream_out_slice #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_out_slice (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_load),
        .i_data  (w_data_nxt),
        .i_keep  (w_keep_nxt),
        .i_last  (w_last_nxt),
        .i_ready (ready_out),
        .o_valid (valid_out),
        .o_data  (data_out),
        .o_keep  (keep_out),
        .o_last  (last_out),
        .o_adv   (w_adv)
    );

endmodule

// File: tb/tb_stream_insert_pipe.sv
// Bench for stream_insert_pipe: byte-stream reference model, directed cases and
// randomized packets with gaps and backpressure.
module tb_stream_insert_pipe;

    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LW  = 3;
    localparam int CW  = 16;
    localparam int TMO = 1000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          valid_in, last_in, ready_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          valid_insert, ready_insert;
    logic [DW-1:0] data_insert;
    logic [LW-1:0] hdr_len;
    logic          valid_out, last_out, ready_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic [CW-1:0] pkt_cnt;
    logic          err_keep;

    always #5 clk = ~clk;

    stream_insert_pipe #(.DATA_WD(DW), .CNT_WD(CW)) dut (
        .clk(clk), .rstn(rstn),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_insert(valid_insert), .data_insert(data_insert), .hdr_len(hdr_len),
        .ready_insert(ready_insert),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out), .pkt_cnt(pkt_cnt), .err_keep(err_keep)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         pay_q[$];
    logic [DW-1:0] hdr_d_q[$];
    logic [LW-1:0] hdr_l_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;
    bit gap_en   = 1'b0;
    bit abort    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] kmask(input logic [BW-1:0] k);
        logic [DW-1:0] m;
        for (int l = 0; l < BW; l++) m[8*l +: 8] = {8{k[l]}};
        return m;
    endfunction

    // Reference: output is header bytes followed by payload bytes, packed MSB-first
    // into full words with a left-aligned final word.
    task automatic model_pkt(input logic [DW-1:0] hdr, input logic [LW-1:0] len, input beat_t beats[$]);
        logic [7:0] bytes[$];
        int         n;
        n = (int'(len) > BW) ? BW : int'(len);
        for (int i = n-1; i >= 0; i--) bytes.push_back(hdr[8*i +: 8]);
        foreach (beats[b])
            for (int l = BW-1; l >= 0; l--)
                if (beats[b].keep[l]) bytes.push_back(beats[b].data[8*l +: 8]);
        while (bytes.size() > 0) begin
            beat_t e;
            e.data = '0;
            e.keep = '0;
            for (int l = BW-1; l >= 0; l--) begin
                if (bytes.size() > 0) begin
                    e.data[8*l +: 8] = bytes.pop_front();
                    e.keep[l] = 1'b1;
                end
            end
            e.last = (bytes.size() == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic add_pkt(input logic [DW-1:0] hdr, input logic [LW-1:0] len, input beat_t beats[$]);
        hdr_d_q.push_back(hdr);
        hdr_l_q.push_back(len);
        foreach (beats[b]) pay_q.push_back(beats[b]);
        model_pkt(hdr, len, beats);
    endtask

    task automatic rand_pkt();
        beat_t    beats[$];
        int       nb;
        int       c;
        beat_t    b;
        nb = $urandom_range(1, 4);
        for (int i = 0; i < nb; i++) begin
            b.data = $urandom;
            b.last = (i == nb-1);
            c = $urandom_range(1, BW);
            b.keep = b.last ? 4'(4'hF << (BW-c)) : 4'hF;
            beats.push_back(b);
        end
        add_pkt($urandom, LW'($urandom_range(0, 4)), beats);
    endtask

    task automatic drive_hdrs();
        while (hdr_d_q.size() > 0 && !abort) begin
            int t;
            t = 0;
            if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
            valid_insert = 1'b1;
            data_insert  = hdr_d_q.pop_front();
            hdr_len      = hdr_l_q.pop_front();
            while (!ready_insert && t < TMO) begin
                @(negedge clk);
                t++;
            end
            if (t >= TMO) begin
                chk("hdr_timeout", 32'(t), 32'(0));
                abort = 1'b1;
            end
            @(negedge clk);
            valid_insert = 1'b0;
            data_insert  = $urandom;
            hdr_len      = LW'($urandom_range(0, 7));
        end
    endtask

    task automatic drive_pay();
        while (pay_q.size() > 0 && !abort) begin
            beat_t b;
            int    t;
            t = 0;
            b = pay_q.pop_front();
            if (gap_en && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            valid_in = 1'b1;
            data_in  = b.data;
            keep_in  = b.keep;
            last_in  = b.last;
            while (!ready_in && t < TMO) begin
                @(negedge clk);
                t++;
            end
            if (t >= TMO) begin
                chk("pay_timeout", 32'(t), 32'(0));
                abort = 1'b1;
            end
            @(negedge clk);
            valid_in = 1'b0;
            last_in  = 1'b0;
        end
    endtask

    task automatic run_all();
        int t;
        fork
            drive_hdrs();
            drive_pay();
        join
        t = 0;
        while (exp_q.size() > 0 && t < 5*TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5*TMO) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Downstream ready changes just after the active edge so it is stable at the sample point.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ready_out = 1'b1;
                1:       ready_out = 1'($urandom_range(0, 1));
                default: ready_out = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        beat_t         e;
        logic          pv, pr, pl;
        logic [DW-1:0] pd, m;
        logic [BW-1:0] pk;
        pv = 1'b0;
        pr = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("stall_valid", 32'(valid_out), 32'(1));
                    chk("stall_data", data_out, pd);
                    chk("stall_keep", 32'(keep_out), 32'(pk));
                    chk("stall_last", 32'(last_out), 32'(pl));
                end
                if (valid_out && ready_out) begin
                    chk("beat_expected", 32'(exp_q.size() > 0), 32'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        m = kmask(e.keep);
                        chk("out_keep", 32'(keep_out), 32'(e.keep));
                        chk("out_data", data_out & m, e.data & m);
                        chk("out_last", 32'(last_out), 32'(e.last));
                    end
                end
                pv = valid_out;
                pr = ready_out;
                pd = data_out;
                pk = keep_out;
                pl = last_out;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        beat_t         beats[$];
        beat_t         b;
        logic [DW-1:0] d[3];

        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; hdr_len = '0;

        repeat (3) @(negedge clk);
        chk("rst_valid_out", 32'(valid_out), 32'(0));
        chk("rst_last_out", 32'(last_out), 32'(0));
        chk("rst_data_out", data_out, 32'(0));
        chk("rst_keep_out", 32'(keep_out), 32'(0));
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'(0));
        chk("rst_err_keep", 32'(err_keep), 32'(0));
        chk("rst_ready_insert", 32'(ready_insert), 32'(1));
        chk("rst_ready_in", 32'(ready_in), 32'(0));
        #2 rstn = 1'b1;
        @(negedge clk);

        // hdr_len=2, no overflow
        beats.delete();
        b.data = 32'h11223344; b.keep = 4'hF; b.last = 1'b0; beats.push_back(b);
        b.data = 32'h55667788; b.keep = 4'h8; b.last = 1'b1; beats.push_back(b);
        add_pkt(32'h0000AABB, 3'd2, beats);
        run_all();
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'(1));

        // hdr_len=2, last beat overflows into a tail
        beats.delete();
        b.data = 32'h11223344; b.keep = 4'hF; b.last = 1'b0; beats.push_back(b);
        b.data = 32'h55667788; b.keep = 4'hE; b.last = 1'b1; beats.push_back(b);
        add_pkt(32'h0000AABB, 3'd2, beats);
        run_all();
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'(2));

        // full-word header
        beats.delete();
        b.data = 32'h01020304; b.keep = 4'hF; b.last = 1'b1; beats.push_back(b);
        add_pkt(32'hDEADBEEF, 3'd4, beats);
        run_all();
        chk("t4_pkt_cnt", 32'(pkt_cnt), 32'(3));

        // oversize hdr_len clamps to a full word
        beats.delete();
        b.data = 32'h99887766; b.keep = 4'hF; b.last = 1'b0; beats.push_back(b);
        b.data = 32'h55443322; b.keep = 4'hC; b.last = 1'b1; beats.push_back(b);
        add_pkt(32'hCAFEF00D, 3'd7, beats);
        run_all();
        chk("clamp_pkt_cnt", 32'(pkt_cnt), 32'(4));

        // hdr_len=0 passthrough with one-cycle latency
        beats.delete();
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            b.data = d[i]; b.keep = 4'hF; b.last = (i == 2); beats.push_back(b);
        end
        model_pkt(32'h0, 3'd0, beats);
        chk("pt_ready_insert", 32'(ready_insert), 32'(1));
        valid_insert = 1'b1; data_insert = $urandom; hdr_len = 3'd0;
        @(negedge clk);
        valid_insert = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; data_in = d[i]; keep_in = 4'hF; last_in = (i == 2);
            chk("pt_ready_in", 32'(ready_in), 32'(1));
            @(negedge clk);
            chk("pt_lat_valid", 32'(valid_out), 32'(1));
            chk("pt_lat_data", data_out, d[i]);
            chk("pt_lat_last", 32'(last_out), 32'(i == 2));
        end
        valid_in = 1'b0; last_in = 1'b0;
        @(negedge clk);
        chk("pt_no_tail", 32'(valid_out), 32'(0));
        @(negedge clk);
        chk("pt_pkt_cnt", 32'(pkt_cnt), 32'(5));

        // reset in the middle of a stalled packet
        rdy_mode = 2;
        @(negedge clk);
        valid_insert = 1'b1; data_insert = 32'h12345678; hdr_len = 3'd1;
        @(negedge clk);
        valid_insert = 1'b0;
        valid_in = 1'b1; data_in = 32'hA1A2A3A4; keep_in = 4'hF; last_in = 1'b0;
        @(negedge clk);
        chk("mid_body_valid", 32'(valid_out), 32'(1));
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_out), 32'(0));
        chk("mid_rst_data", data_out, 32'(0));
        chk("mid_rst_keep", 32'(keep_out), 32'(0));
        chk("mid_rst_last", 32'(last_out), 32'(0));
        chk("mid_rst_ready_insert", 32'(ready_insert), 32'(1));
        chk("mid_rst_ready_in", 32'(ready_in), 32'(0));
        chk("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'(0));
        exp_q.delete();
        valid_in = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        rdy_mode = 0;
        @(negedge clk);

        beats.delete();
        b.data = 32'h0BADC0DE; b.keep = 4'hF; b.last = 1'b0; beats.push_back(b);
        b.data = 32'hFEEDFACE; b.keep = 4'hC; b.last = 1'b1; beats.push_back(b);
        add_pkt(32'h00112233, 3'd3, beats);
        run_all();
        chk("post_rst_pkt_cnt", 32'(pkt_cnt), 32'(1));
        chk("post_rst_err_keep", 32'(err_keep), 32'(0));

        // non-contiguous keep on last beat; data still passes through unchanged
        hdr_d_q.push_back(32'h0); hdr_l_q.push_back(3'd0);
        b.data = 32'h1A2B3C4D; b.keep = 4'b0101; b.last = 1'b1;
        pay_q.push_back(b);
        exp_q.push_back(b);
        run_all();
        chk("bad_keep_err", 32'(err_keep), 32'(1));
        chk("bad_keep_pkt_cnt", 32'(pkt_cnt), 32'(2));
        @(negedge clk);
        chk("bad_keep_sticky", 32'(err_keep), 32'(1));

        #2 rstn = 1'b0;
        @(negedge clk);
        chk("rst_clears_err", 32'(err_keep), 32'(0));
        #2 rstn = 1'b1;
        @(negedge clk);

        // randomized packets with gaps and 50% backpressure
        rdy_mode = 1;
        gap_en   = 1'b1;
        for (int p = 0; p < 100; p++) rand_pkt();
        run_all();
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        chk("rand_pkt_cnt", 32'(pkt_cnt), 32'(100));
        chk("rand_err_keep", 32'(err_keep), 32'(0));
        chk("rand_leftover", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
